array_mult_8: RTL and testbench
===============================

# array_mult_8

Unsigned 8×8 array multiplier producing a full 16-bit product. Built as a regular carry-save array of AND-gate partial products and full-adder cells with a ripple final row, followed by an output register. It serves as a reference and benchmark datapath alongside the faster multiplier variants, so its structure must remain a literal array and must not be replaced by a `*` operator.

## Interface
- No parameters. Widths are fixed: operands are 8 bits and the product is 16 bits.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `A` input 8: multiplicand, unsigned.
- `B` input 8: multiplier, unsigned.
- `in_valid` input 1: qualifies `A`/`B` this cycle.
- `product` output 16: registered A×B, unsigned.
- `out_valid` output 1: `product` holds a result launched by a qualified input.

## Operation
- Partial products: pp[i][j] = A[j] & B[i], for i, j in 0..7.
- Row 0 is pp[0][*].
- Rows 1..7 each add pp[i][*] into the running sum/carry vectors using full-adder cells.
  - Carry-save form: carries pass diagonally to the next row, not along the row.
- The final row is an 8-bit ripple-carry adder that resolves the remaining sum and carry into bits 15:8.
- Bits 7:0 are the LSB sum taken from each row.
- Result is exact over the whole range; no overflow is possible.
  - Maximum product: 255×255 = 65025 = 16'hFE01.
- `product` is captured every cycle regardless of `in_valid`.
  - `in_valid` only travels alongside the data as `out_valid`.
  - Consumers must ignore `product` when `out_valid` is low.
- Operands are treated strictly as unsigned. No signed mode exists.

## Timing
- Reset (`rst_n` low, asynchronous): `product` = 16'h0000 and `out_valid` = 0 immediately, without waiting for a clock edge.
- Default latency is 1 cycle:
  - `A`/`B`/`in_valid` sampled at edge N appear on `product`/`out_valid` after edge N.
  - Throughput is one result per cycle, with no stalls and no back-pressure.
- Back-to-back changes of `A`/`B` produce back-to-back results in order.
- Reset deasserting mid-stream: the first result follows the first edge after release.
  - Any pipeline contents held before reset are discarded and are never reported valid.
- The combinational array must settle within one clock period. The critical path is the diagonal carry chain plus the final ripple.

## Configuration
- `ARRAY_MULT_8_PIPE_EN` defined:
  - A pipeline register is inserted after array row 4. It holds partial sum, partial carry, the completed low product bits, the B[7:5] rows' operands and valid.
  - Latency becomes 2 cycles; throughput stays at 1 per cycle.
  - The pipeline register also resets asynchronously to 0.
- `ARRAY_MULT_8_PIPE_EN` undefined: single output register, latency 1.

## Structure
- A shared package `mult_pkg` holds:
  - `MULT_W` = 8 and `PROD_W` = 16.
  - typedef `operand_t` (logic [7:0]) and typedef `product_t` (logic [15:0]).
  - The latency constant, which depends on `ARRAY_MULT_8_PIPE_EN`.
- One sub-module, `full_adder` (a, b, cin → s, cout), is instantiated across the array by generate loops. Half-adder positions use `full_adder` with cin tied to 0.
- The top level contains the partial-product AND plane, the generate array, the final ripple row, and the registers.

## Test plan
- Reset: assert `rst_n`=0 with A=8'hFF, B=8'hFF → `product`=0 and `out_valid`=0 without any clock edge. Release → 65025 appears after the latency.
- Zero: A=1, B=0, `in_valid`=1 → `product`=0, `out_valid`=1 after the latency.
- Small: A=10, B=3 → `product`=30. Then back-to-back A=208, B=160 on the next cycle → 33280 on consecutive cycles, in order.
- Maximum: A=255, B=255 → `product`=65025 (16'hFE01).
- Exhaustive: all 65536 A/B pairs streamed one per cycle, checked against a model A*B after the latency. Run once with `ARRAY_MULT_8_PIPE_EN` defined and once without.
- Valid tracking: toggle `in_valid` 1,0,1 with A=2, B=7 → `out_valid` follows 1,0,1 delayed by the latency; `product`=14 on the valid cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and types for the array multiplier.
//
// Contents:
//   MULT_W    - operand width (8)
//   PROD_W    - product width (16)
//   operand_t - logic [7:0]
//   product_t - logic [15:0]
//   LATENCY   - cycles from sampled operands to registered product
//
// Configuration macro: ARRAY_MULT_8_PIPE_EN
//   Defined: an extra register after array row 4, so LATENCY is 2.
//   Undefined: LATENCY is 1.
package mult_pkg;

    localparam int unsigned MULT_W = 8;
    localparam int unsigned PROD_W = 16;

    typedef logic [MULT_W-1:0] operand_t;
    typedef logic [PROD_W-1:0] product_t;

`ifdef ARRAY_MULT_8_PIPE_EN
    localparam int unsigned LATENCY = 2;
`else
    localparam int unsigned LATENCY = 1;
`endif

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used throughout the multiplier array.
//
// Ports:
//   a, b, cin - input bits
//   s         - sum bit
//   cout      - carry out
// Half-adder positions are built from this cell with cin tied to 0.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_xor;

    assign ab_xor = a ^ b;
    assign s      = ab_xor ^ cin;
    assign cout   = (a & b) | (cin & ab_xor);

endmodule

// File: rtl/array_mult_8.sv
// Unsigned 8x8 carry-save array multiplier with a registered 16-bit product.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   A, B      - unsigned operands
//   in_valid  - qualifies A/B this cycle
//   product   - registered A*B
//   out_valid - product belongs to a qualified input
//
// Structure: an AND plane of partial products, seven carry-save rows of
// full_adder cells (carries move diagonally to the next row), and an 8-bit
// ripple row that resolves bits 15:8. Bits 7:0 are each row's LSB sum.
//
// Configuration macro: ARRAY_MULT_8_PIPE_EN
//   Defined: a register after row 4 holds the partial sum/carry, low product
//   bits 4:0, A, B[7:5] and valid, giving a latency of 2.
//   Undefined: only the output register, latency 1.
module array_mult_8
    import mult_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  operand_t A,
    input  operand_t B,
    input  logic     in_valid,
    output product_t product,
    output logic     out_valid
);

    // pp[i][j] = A[j] & B[i]; rows 5..7 may come from the mid-array register
    logic [MULT_W-1:0] pp [MULT_W];

    operand_t    a_late;     // multiplicand feeding rows 5..7
    logic [2:0]  b_late;     // B[7:5] feeding rows 5..7
    logic        valid_mid;  // valid arriving at the output register
    logic [7:0]  lo_bits;    // LSB sum of each row
    logic [7:0]  prod_lo;    // low product byte as seen by the output register
    logic [7:0]  hi_bits;    // ripple row result
    logic [7:0]  fin_a;      // remaining sum bits entering the ripple row
    logic        unused_carry;

`ifdef ARRAY_MULT_8_PIPE_EN
    logic [7:0] mid_sum_q;
    logic [7:0] mid_carry_q;
    logic [4:0] mid_lo_q;
    operand_t   mid_a_q;
    logic [2:0] mid_b_q;
    logic       mid_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_sum_q   <= '0;
            mid_carry_q <= '0;
            mid_lo_q    <= '0;
            mid_a_q     <= '0;
            mid_b_q     <= '0;
            mid_valid_q <= 1'b0;
        end else begin
            mid_sum_q   <= g_row[4].s;
            mid_carry_q <= g_row[4].c;
            mid_lo_q    <= lo_bits[4:0];
            mid_a_q     <= A;
            mid_b_q     <= B[7:5];
            mid_valid_q <= in_valid;
        end
    end

    assign a_late    = mid_a_q;
    assign b_late    = mid_b_q;
    assign valid_mid = mid_valid_q;
    assign prod_lo   = {lo_bits[7:5], mid_lo_q};
`else
    assign a_late    = A;
    assign b_late    = B[7:5];
    assign valid_mid = in_valid;
    assign prod_lo   = lo_bits;
`endif

    // Partial-product AND plane
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pp[i] = A & {MULT_W{B[i]}};
        end
        for (int i = 5; i < 8; i++) begin
            pp[i] = a_late & {MULT_W{b_late[i-5]}};
        end
    end

    // Carry-save rows. Row i cell j adds pp[i][j], the previous row's sum
    // one column to the left, and the previous row's carry from column j;
    // all three share weight i+j, so no carry travels along a row.
    for (genvar i = 0; i < MULT_W; i++) begin : g_row
        logic [7:0] s;
        logic [7:0] c;

        if (i == 0) begin : g_first
            assign s = pp[0];
            assign c = '0;
        end else begin : g_add
            logic [7:0] s_in;
            logic [7:0] c_in;

`ifdef ARRAY_MULT_8_PIPE_EN
            if (i == 5) begin : g_from_reg
                assign s_in = {1'b0, mid_sum_q[7:1]};
                assign c_in = mid_carry_q;
            end else begin : g_from_row
                assign s_in = {1'b0, g_row[i-1].s[7:1]};
                assign c_in = g_row[i-1].c;
            end
`else
            assign s_in = {1'b0, g_row[i-1].s[7:1]};
            assign c_in = g_row[i-1].c;
`endif

            for (genvar j = 0; j < MULT_W; j++) begin : g_col
                full_adder u_fa (
                    .a    (pp[i][j]),
                    .b    (s_in[j]),
                    .cin  (c_in[j]),
                    .s    (s[j]),
                    .cout (c[j])
                );
            end
        end

        assign lo_bits[i] = s[0];
    end

    // Final ripple row resolves bits 15:8
    assign fin_a = {1'b0, g_row[7].s[7:1]};

    for (genvar k = 0; k < MULT_W; k++) begin : g_fin
        logic ci;
        logic co;

        if (k == 0) begin : g_cin0
            assign ci = 1'b0;
        end else begin : g_cin
            assign ci = g_fin[k-1].co;
        end

        full_adder u_fa (
            .a    (fin_a[k]),
            .b    (g_row[7].c[k]),
            .cin  (ci),
            .s    (hi_bits[k]),
            .cout (co)
        );
    end

    // 255*255 fits in 16 bits, so the last carry is always zero
    assign unused_carry = g_fin[7].co;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            product   <= {hi_bits, prod_lo};
            out_valid <= valid_mid;
        end
    end

endmodule

// File: tb/tb_array_mult_8.sv
// Self-checking bench for array_mult_8: directed cases plus randomized
// operands, compared against a plain A*B model delayed by LATENCY cycles.
module tb_array_mult_8;
    import mult_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b1;
    operand_t A = '0;
    operand_t B = '0;
    logic     in_valid = 1'b0;
    product_t product;
    logic     out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    typedef struct packed {
        logic     v;
        product_t p;
        logic     known;
    } exp_t;

    exp_t hist[$];

    array_mult_8 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .product   (product),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Results launched before a reset are never valid; after release the
    // first LATENCY-1 outputs carry nothing from the model.
    task automatic reset_model();
        exp_t pad;
        pad.v     = 1'b0;
        pad.p     = '0;
        pad.known = 1'b0;
        hist.delete();
        for (int i = 1; i < int'(LATENCY); i++) hist.push_back(pad);
    endtask

    // Called at a falling edge: apply inputs, let one rising edge pass,
    // check the outputs on the next falling edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
        exp_t e;
        exp_t cur;
        A        = a;
        B        = b;
        in_valid = v;
        cur.v     = v;
        cur.p     = 16'(a) * 16'(b);
        cur.known = 1'b1;
        hist.push_back(cur);
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
        e = hist.pop_front();
        check_eq($sformatf("out_valid@%0d", n_cyc), 32'(out_valid), 32'(e.v));
        if (e.known) check_eq($sformatf("product@%0d", n_cyc), 32'(product), 32'(e.p));
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_product"}, 32'(product), 32'd0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        // Reset with all-ones operands, checked before any clock edge
        A        = 8'hFF;
        B        = 8'hFF;
        in_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_product", 32'(product), 32'd0);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_held_product", 32'(product), 32'd0);
        check_eq("reset_held_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 3; i++) drive(8'hFF, 8'hFF, 1'b1);

        // Directed corners
        drive(8'd1, 8'd0, 1'b1);
        drive(8'd10, 8'd3, 1'b1);
        drive(8'd208, 8'd160, 1'b1);
        drive(8'd255, 8'd255, 1'b1);
        drive(8'd0, 8'd255, 1'b1);
        drive(8'd128, 8'd128, 1'b1);
        // Valid tracking 1,0,1
        drive(8'd2, 8'd7, 1'b1);
        drive(8'd2, 8'd7, 1'b0);
        drive(8'd2, 8'd7, 1'b1);
        for (int i = 0; i < 4; i++) drive(8'd0, 8'd0, 1'b0);

        // Randomized stream
        for (int i = 0; i < 2000; i++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom_range(3, 0) != 0));
        end

        // Reset in mid-stream with a live, valid pipeline
        for (int i = 0; i < 3; i++) drive(8'hFF, 8'($urandom_range(255, 1)), 1'b1);
        async_reset_check("midreset");
        for (int i = 0; i < 4; i++) drive(8'($urandom), 8'($urandom), 1'b1);

        // Walking one-hot operands exercise individual rows and columns
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                drive(8'(1 << i), 8'(1 << j), 1'b1);
            end
        end

        for (int i = 0; i < 1000; i++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 3; i++) drive(8'd0, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
